// File: rtl/mem_req_issue.sv
// Execute-stage load/store issuer: computes rs1+imm, emits one memory-op beat, then aligns/extends the load response into a register write.
// Optional MEM_MISALIGN_TRAP_EN: refuse misaligned H/W ops with an oMisalign pulse instead of force-aligning them.
module mem_req_issue #(
  parameter int unsigned cXLEN        = 32,
  parameter int unsigned cLoadLatency = 2,
  parameter int unsigned cTimeout     = 15
) (
  input  logic             iClk,
  input  logic             iRst,
  input  logic             iValid,
  output logic             oReady,
  input  logic             iIsLoad,
  input  logic [2:0]       iFunct3,
  input  logic [cXLEN-1:0] iRs1,
  input  logic [cXLEN-1:0] iRs2,
  input  logic [cXLEN-1:0] iImm,
  input  logic [4:0]       iRdAddr,
  input  logic             iFlush,
  output logic             oMemRead,
  output logic             oMemWrite,
  output logic [cXLEN-1:0] oMemAddr,
  output logic [cXLEN-1:0] oMemData,
  output logic [2:0]       oMemOpType,
  output logic [4:0]       oMemRdAddr,
  input  logic             iLoadDv,
  input  logic [4:0]       iLoadAddr,
  input  logic [cXLEN-1:0] iLoadData,
  output logic             oWbDv,
  output logic [4:0]       oWbAddr,
  output logic [cXLEN-1:0] oWbData,
  output logic             oLoadPend,
  output logic [4:0]       oLoadPendRd,
  output logic             oLoadLate,
  output logic             oTimeout,
  output logic             oMisalign
);

  localparam int unsigned CntW = 8;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_LOAD} state_e;

  state_e            state_q, state_d;
  logic              ready_q, ready_d;
  logic              rd_stb_q, rd_stb_d;
  logic              wr_stb_q, wr_stb_d;
  logic              is_load_q, is_load_d;
  logic [cXLEN-1:0]  addr_q, addr_d;
  logic [cXLEN-1:0]  data_q, data_d;
  logic [2:0]        op_q, op_d;
  logic [4:0]        rd_q, rd_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              pend_q, pend_d;
  logic [4:0]        pend_rd_q, pend_rd_d;
  logic              wb_dv_q, wb_dv_d;
  logic [4:0]        wb_addr_q, wb_addr_d;
  logic [cXLEN-1:0]  wb_data_q, wb_data_d;
  logic              late_q, late_d;
  logic              timeout_q, timeout_d;
  logic              misalign_d;

  logic [cXLEN-1:0]  ea, ea_issue, ld_ext;
  logic [7:0]        ld_byte;
  logic [15:0]       ld_half;

  // Effective address, with H/W low bits cleared to natural alignment
  always_comb begin
    ea       = iRs1 + iImm;
    ea_issue = ea;
    if (iFunct3 == 3'b001 || iFunct3 == 3'b101) ea_issue[0] = 1'b0;
    if (iFunct3 == 3'b010) ea_issue[1:0] = 2'b00;
  end

  // Byte-lane select and sign/zero extension of the returned word
  always_comb begin
    ld_byte = iLoadData[{addr_q[1:0], 3'b000} +: 8];
    ld_half = addr_q[1] ? iLoadData[31:16] : iLoadData[15:0];
    case (op_q)
      3'b000:  ld_ext = {{(cXLEN-8){ld_byte[7]}}, ld_byte};
      3'b100:  ld_ext = cXLEN'(ld_byte);
      3'b001:  ld_ext = {{(cXLEN-16){ld_half[15]}}, ld_half};
      3'b101:  ld_ext = cXLEN'(ld_half);
      3'b010:  ld_ext = iLoadData;
      default: ld_ext = '0;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    ready_d    = ready_q;
    rd_stb_d   = 1'b0;
    wr_stb_d   = 1'b0;
    is_load_d  = is_load_q;
    addr_d     = addr_q;
    data_d     = data_q;
    op_d       = op_q;
    rd_d       = rd_q;
    cnt_d      = cnt_q;
    pend_d     = pend_q;
    pend_rd_d  = pend_rd_q;
    wb_dv_d    = 1'b0;
    wb_addr_d  = wb_addr_q;
    wb_data_d  = wb_data_q;
    late_d     = 1'b0;
    timeout_d  = 1'b0;
    misalign_d = 1'b0;
    case (state_q)
      IDLE: begin
        ready_d = 1'b1;
        if (ready_q && iValid && !iFlush) begin
          if (ea_issue != ea) begin
`ifdef MEM_MISALIGN_TRAP_EN
            misalign_d = 1'b1;
            ready_d    = 1'b0;
`else
            misalign_d = 1'b0;
`endif
          end
          if (!misalign_d) begin
            state_d   = ISSUE;
            ready_d   = 1'b0;
            rd_stb_d  = iIsLoad;
            wr_stb_d  = !iIsLoad;
            is_load_d = iIsLoad;
            addr_d    = ea_issue;
            data_d    = iRs2;
            op_d      = iFunct3;
            rd_d      = iRdAddr;
          end
        end
      end
      ISSUE: begin
        if (iFlush || !is_load_q) begin
          state_d = IDLE;
          ready_d = 1'b1;
        end else begin
          state_d   = WAIT_LOAD;
          cnt_d     = '0;
          pend_d    = 1'b1;
          pend_rd_d = rd_q;
        end
      end
      WAIT_LOAD: begin
        cnt_d = cnt_q + CntW'(1);
        // Priority: flush, then matching response, then timeout
        if (iFlush) begin
          state_d = IDLE;
        end else if (iLoadDv && iLoadAddr == rd_q) begin
          state_d   = IDLE;
          wb_dv_d   = (rd_q != 5'd0);
          wb_addr_d = rd_q;
          wb_data_d = ld_ext;
          late_d    = (cnt_q > CntW'(cLoadLatency));
        end else if (cnt_q == CntW'(cTimeout - 1)) begin
          state_d   = IDLE;
          timeout_d = 1'b1;
        end
        if (state_d == IDLE) begin
          ready_d   = 1'b1;
          pend_d    = 1'b0;
          pend_rd_d = 5'd0;
        end
      end
      default: begin
        state_d = IDLE;
        ready_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge iClk or negedge iRst) begin
    if (!iRst) begin
      state_q   <= IDLE;
      ready_q   <= 1'b1;
      rd_stb_q  <= 1'b0;
      wr_stb_q  <= 1'b0;
      is_load_q <= 1'b0;
      addr_q    <= '0;
      data_q    <= '0;
      op_q      <= 3'b000;
      rd_q      <= 5'd0;
      cnt_q     <= '0;
      pend_q    <= 1'b0;
      pend_rd_q <= 5'd0;
      wb_dv_q   <= 1'b0;
      wb_addr_q <= 5'd0;
      wb_data_q <= '0;
      late_q    <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ready_q   <= ready_d;
      rd_stb_q  <= rd_stb_d;
      wr_stb_q  <= wr_stb_d;
      is_load_q <= is_load_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      op_q      <= op_d;
      rd_q      <= rd_d;
      cnt_q     <= cnt_d;
      pend_q    <= pend_d;
      pend_rd_q <= pend_rd_d;
      wb_dv_q   <= wb_dv_d;
      wb_addr_q <= wb_addr_d;
      wb_data_q <= wb_data_d;
      late_q    <= late_d;
      timeout_q <= timeout_d;
    end
  end

`ifdef MEM_MISALIGN_TRAP_EN
  logic misalign_q;
  always_ff @(posedge iClk or negedge iRst) begin
    if (!iRst) misalign_q <= 1'b0;
    else       misalign_q <= misalign_d;
  end
  assign oMisalign = misalign_q;
`else
  assign oMisalign = 1'b0;
`endif

  // A flush during the ISSUE cycle must kill the already-registered strobe
  assign oMemRead    = rd_stb_q & ~iFlush;
  assign oMemWrite   = wr_stb_q & ~iFlush;
  assign oReady      = ready_q;
  assign oMemAddr    = addr_q;
  assign oMemData    = data_q;
  assign oMemOpType  = op_q;
  assign oMemRdAddr  = rd_q;
  assign oWbDv       = wb_dv_q;
  assign oWbAddr     = wb_addr_q;
  assign oWbData     = wb_data_q;
  assign oLoadPend   = pend_q;
  assign oLoadPendRd = pend_rd_q;
  assign oLoadLate   = late_q;
  assign oTimeout    = timeout_q;

endmodule

// File: tb/tb_mem_req_issue.sv
// Directed bench for mem_req_issue: table of load/store vectors plus hand-written flush, timeout, reset and alignment sequences.
module tb_mem_req_issue;

  logic        iClk, iRst, iValid, oReady, iIsLoad, iFlush;
  logic [2:0]  iFunct3, oMemOpType;
  logic [31:0] iRs1, iRs2, iImm, oMemAddr, oMemData, iLoadData, oWbData;
  logic [4:0]  iRdAddr, oMemRdAddr, iLoadAddr, oWbAddr, oLoadPendRd;
  logic        oMemRead, oMemWrite, iLoadDv, oWbDv, oLoadPend, oLoadLate, oTimeout, oMisalign;

  int n_cmp = 0;
  int n_err = 0;

  mem_req_issue dut (
    .iClk(iClk), .iRst(iRst), .iValid(iValid), .oReady(oReady), .iIsLoad(iIsLoad),
    .iFunct3(iFunct3), .iRs1(iRs1), .iRs2(iRs2), .iImm(iImm), .iRdAddr(iRdAddr),
    .iFlush(iFlush), .oMemRead(oMemRead), .oMemWrite(oMemWrite), .oMemAddr(oMemAddr),
    .oMemData(oMemData), .oMemOpType(oMemOpType), .oMemRdAddr(oMemRdAddr),
    .iLoadDv(iLoadDv), .iLoadAddr(iLoadAddr), .iLoadData(iLoadData), .oWbDv(oWbDv),
    .oWbAddr(oWbAddr), .oWbData(oWbData), .oLoadPend(oLoadPend), .oLoadPendRd(oLoadPendRd),
    .oLoadLate(oLoadLate), .oTimeout(oTimeout), .oMisalign(oMisalign)
  );

  initial iClk = 1'b0;
  always #5 iClk = ~iClk;

  typedef struct {
    logic        ld;
    logic [2:0]  f3;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [31:0] imm;
    logic [4:0]  rd;
    int          dly;
    logic [31:0] rdata;
    logic [31:0] exp_addr;
    logic        exp_wbdv;
    logic [31:0] exp_wb;
    logic        exp_late;
  } vec_t;

  localparam int NVEC = 12;
  vec_t vecs[NVEC];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Offer one op in the current IDLE cycle; returns at the ISSUE-cycle sample point
  task automatic offer(input vec_t v);
    chk("ready_idle", 32'(oReady), 32'd1);
    iValid = 1'b1; iIsLoad = v.ld; iFunct3 = v.f3; iRs1 = v.rs1;
    iRs2 = v.rs2; iImm = v.imm; iRdAddr = v.rd;
    @(negedge iClk);
    iValid = 1'b0;
  endtask

  task automatic run_vec(input vec_t v);
    offer(v);
    chk("issue_rd_stb", 32'(oMemRead), 32'(v.ld));
    chk("issue_wr_stb", 32'(oMemWrite), 32'(!v.ld));
    chk("issue_addr", oMemAddr, v.exp_addr);
    chk("issue_op", 32'(oMemOpType), 32'(v.f3));
    chk("issue_ready", 32'(oReady), 32'd0);
    if (!v.ld) begin
      chk("issue_data", oMemData, v.rs2);
      @(negedge iClk);
      chk("store_done_ready", 32'(oReady), 32'd1);
      chk("store_done_stb", 32'(oMemWrite), 32'd0);
    end else begin
      chk("issue_rdtag", 32'(oMemRdAddr), 32'(v.rd));
      @(negedge iClk);
      chk("wait_pend", 32'(oLoadPend), 32'd1);
      chk("wait_pend_rd", 32'(oLoadPendRd), 32'(v.rd));
      chk("wait_rd_stb", 32'(oMemRead), 32'd0);
      repeat (v.dly) @(negedge iClk);
      iLoadDv = 1'b1; iLoadAddr = v.rd; iLoadData = v.rdata;
      @(negedge iClk);
      iLoadDv = 1'b0;
      chk("wb_dv", 32'(oWbDv), 32'(v.exp_wbdv));
      if (v.exp_wbdv) begin
        chk("wb_addr", 32'(oWbAddr), 32'(v.rd));
        chk("wb_data", oWbData, v.exp_wb);
      end
      chk("wb_late", 32'(oLoadLate), 32'(v.exp_late));
      chk("wb_no_timeout", 32'(oTimeout), 32'd0);
      chk("wb_pend_clr", 32'(oLoadPend), 32'd0);
      chk("wb_ready", 32'(oReady), 32'd1);
      @(negedge iClk);
      chk("wb_dv_pulse", 32'(oWbDv), 32'd0);
    end
  endtask

  function automatic vec_t mk_load(input logic [2:0] f3, input logic [31:0] rs1,
                                   input logic [31:0] imm, input logic [4:0] rd);
    vec_t v;
    v = '{1'b1, f3, rs1, 32'h0, imm, rd, 0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0};
    return v;
  endfunction

  initial begin
    vec_t v;
    vecs[0]  = '{1'b0, 3'b010, 32'h0000_0100, 32'hDEAD_BEEF, 32'h0000_0008, 5'd0,  0, 32'h0,         32'h0000_0108, 1'b0, 32'h0,         1'b0};
    vecs[1]  = '{1'b1, 3'b000, 32'h0000_0200, 32'h0,         32'h0000_0001, 5'd5,  1, 32'h0000_8000, 32'h0000_0201, 1'b1, 32'hFFFF_FF80, 1'b0};
    vecs[2]  = '{1'b1, 3'b100, 32'h0000_0200, 32'h0,         32'h0000_0001, 5'd5,  3, 32'h0000_8000, 32'h0000_0201, 1'b1, 32'h0000_0080, 1'b1};
    vecs[3]  = '{1'b1, 3'b001, 32'h0000_0200, 32'h0,         32'h0000_0002, 5'd0,  0, 32'h8001_0000, 32'h0000_0202, 1'b0, 32'h0,         1'b0};
    vecs[4]  = '{1'b1, 3'b001, 32'h0000_0200, 32'h0,         32'h0000_0002, 5'd7,  2, 32'h8001_0000, 32'h0000_0202, 1'b1, 32'hFFFF_8001, 1'b0};
    vecs[5]  = '{1'b1, 3'b101, 32'h0000_0200, 32'h0,         32'h0000_0002, 5'd7,  0, 32'h8001_0000, 32'h0000_0202, 1'b1, 32'h0000_8001, 1'b0};
    vecs[6]  = '{1'b1, 3'b010, 32'h0000_1000, 32'h0,         32'hFFFF_FFFC, 5'd31, 0, 32'h1234_5678, 32'h0000_0FFC, 1'b1, 32'h1234_5678, 1'b0};
    vecs[7]  = '{1'b0, 3'b000, 32'hFFFF_FFF0, 32'h0000_00A5, 32'h0000_0020, 5'd0,  0, 32'h0,         32'h0000_0010, 1'b0, 32'h0,         1'b0};
    vecs[8]  = '{1'b1, 3'b000, 32'h0000_0300, 32'h0,         32'h0000_0003, 5'd9,  0, 32'h7F00_0000, 32'h0000_0303, 1'b1, 32'h0000_007F, 1'b0};
    vecs[9]  = '{1'b1, 3'b100, 32'h0000_0400, 32'h0,         32'h0000_0000, 5'd10, 0, 32'h0000_00FF, 32'h0000_0400, 1'b1, 32'h0000_00FF, 1'b0};
    vecs[10] = '{1'b1, 3'b011, 32'h0000_0400, 32'h0,         32'h0000_0008, 5'd4,  0, 32'hFFFF_FFFF, 32'h0000_0408, 1'b1, 32'h0000_0000, 1'b0};
    // Response in the final wait cycle, coinciding with the timeout point
    vecs[11] = '{1'b1, 3'b010, 32'h0000_0500, 32'h0,         32'h0000_0000, 5'd12, 14, 32'hCAFE_F00D, 32'h0000_0500, 1'b1, 32'hCAFE_F00D, 1'b1};

    iRst = 1'b0; iValid = 1'b0; iIsLoad = 1'b0; iFunct3 = 3'b000; iRs1 = '0; iRs2 = '0;
    iImm = '0; iRdAddr = '0; iFlush = 1'b0; iLoadDv = 1'b0; iLoadAddr = '0; iLoadData = '0;
    repeat (2) @(negedge iClk);
    chk("rst_ready", 32'(oReady), 32'd1);
    chk("rst_rd_stb", 32'(oMemRead), 32'd0);
    chk("rst_wr_stb", 32'(oMemWrite), 32'd0);
    chk("rst_addr", oMemAddr, 32'h0);
    chk("rst_wbdv", 32'(oWbDv), 32'd0);
    chk("rst_pend", 32'(oLoadPend), 32'd0);
    chk("rst_timeout", 32'(oTimeout), 32'd0);
    chk("rst_misalign", 32'(oMisalign), 32'd0);
    iRst = 1'b1;
    @(negedge iClk);

    for (int i = 0; i < NVEC; i++) run_vec(vecs[i]);

    // Mismatched response tag is ignored
    v = mk_load(3'b010, 32'h600, 32'h0, 5'd6);
    offer(v);
    @(negedge iClk);
    iLoadDv = 1'b1; iLoadAddr = 5'd2; iLoadData = 32'h1111_1111;
    @(negedge iClk);
    chk("badtag_pend", 32'(oLoadPend), 32'd1);
    chk("badtag_wbdv", 32'(oWbDv), 32'd0);
    iLoadAddr = 5'd6; iLoadData = 32'h2222_2222;
    @(negedge iClk);
    iLoadDv = 1'b0;
    chk("goodtag_wbdv", 32'(oWbDv), 32'd1);
    chk("goodtag_data", oWbData, 32'h2222_2222);
    @(negedge iClk);

    // Timeout, then a stale response for the same tag
    v = mk_load(3'b010, 32'h700, 32'h0, 5'd10);
    offer(v);
    @(negedge iClk);
    repeat (14) @(negedge iClk);
    chk("to_pend_before", 32'(oLoadPend), 32'd1);
    chk("to_pulse_before", 32'(oTimeout), 32'd0);
    @(negedge iClk);
    chk("to_pulse", 32'(oTimeout), 32'd1);
    chk("to_pend_clr", 32'(oLoadPend), 32'd0);
    chk("to_no_wb", 32'(oWbDv), 32'd0);
    chk("to_ready", 32'(oReady), 32'd1);
    iLoadDv = 1'b1; iLoadAddr = 5'd10; iLoadData = 32'h3333_3333;
    @(negedge iClk);
    iLoadDv = 1'b0;
    chk("to_stale_wb", 32'(oWbDv), 32'd0);
    chk("to_pulse_end", 32'(oTimeout), 32'd0);

    // Flush in WAIT_LOAD, rd=3, response two cycles later
    v = mk_load(3'b010, 32'h800, 32'h0, 5'd3);
    offer(v);
    @(negedge iClk);
    iFlush = 1'b1;
    @(negedge iClk);
    iFlush = 1'b0;
    chk("flw_pend", 32'(oLoadPend), 32'd0);
    chk("flw_ready", 32'(oReady), 32'd1);
    @(negedge iClk);
    iLoadDv = 1'b1; iLoadAddr = 5'd3; iLoadData = 32'h4444_4444;
    @(negedge iClk);
    iLoadDv = 1'b0;
    chk("flw_no_wb", 32'(oWbDv), 32'd0);

    // Flush and matching response in the same cycle: flush wins
    v = mk_load(3'b010, 32'h900, 32'h0, 5'd8);
    offer(v);
    @(negedge iClk);
    iFlush = 1'b1; iLoadDv = 1'b1; iLoadAddr = 5'd8; iLoadData = 32'h5555_5555;
    @(negedge iClk);
    iFlush = 1'b0; iLoadDv = 1'b0;
    chk("flrsp_no_wb", 32'(oWbDv), 32'd0);
    chk("flrsp_pend", 32'(oLoadPend), 32'd0);

    // Flush during ISSUE kills the strobe
    v = mk_load(3'b010, 32'hA00, 32'h0, 5'd11);
    offer(v);
    chk("fli_stb_pre", 32'(oMemRead), 32'd1);
    iFlush = 1'b1;
    #1 chk("fli_stb_killed", 32'(oMemRead), 32'd0);
    @(negedge iClk);
    iFlush = 1'b0;
    chk("fli_ready", 32'(oReady), 32'd1);
    chk("fli_pend", 32'(oLoadPend), 32'd0);

    // Flush in IDLE blocks acceptance
    iValid = 1'b1; iIsLoad = 1'b0; iFunct3 = 3'b010; iRs1 = 32'hB00; iImm = 32'h0; iFlush = 1'b1;
    @(negedge iClk);
    iValid = 1'b0; iFlush = 1'b0;
    chk("fle_no_wr", 32'(oMemWrite), 32'd0);
    chk("fle_ready", 32'(oReady), 32'd1);

    // Reset asserted mid-wait
    v = mk_load(3'b010, 32'hC00, 32'h0, 5'd13);
    offer(v);
    @(negedge iClk);
    iRst = 1'b0;
    #1;
    chk("mrst_ready", 32'(oReady), 32'd1);
    chk("mrst_pend", 32'(oLoadPend), 32'd0);
    @(negedge iClk);
    iRst = 1'b1;
    iLoadDv = 1'b1; iLoadAddr = 5'd13; iLoadData = 32'h6666_6666;
    @(negedge iClk);
    iLoadDv = 1'b0;
    chk("mrst_no_wb", 32'(oWbDv), 32'd0);

    // Word load at 0x103
    v = mk_load(3'b010, 32'h100, 32'h3, 5'd14);
    offer(v);
`ifdef MEM_MISALIGN_TRAP_EN
    chk("mis_pulse", 32'(oMisalign), 32'd1);
    chk("mis_no_rd", 32'(oMemRead), 32'd0);
    chk("mis_ready_drop", 32'(oReady), 32'd0);
    @(negedge iClk);
    chk("mis_pulse_end", 32'(oMisalign), 32'd0);
    chk("mis_ready_back", 32'(oReady), 32'd1);
`else
    chk("mis_rd_stb", 32'(oMemRead), 32'd1);
    chk("mis_aligned_addr", oMemAddr, 32'h0000_0100);
    chk("mis_tied", 32'(oMisalign), 32'd0);
    @(negedge iClk);
    iLoadDv = 1'b1; iLoadAddr = 5'd14; iLoadData = 32'h7777_8888;
    @(negedge iClk);
    iLoadDv = 1'b0;
    chk("mis_wb_data", oWbData, 32'h7777_8888);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
